// File: rtl/stream_mux4to1_rr_pkg.sv
// Shared definitions for the 4-to-1 round-robin stream multiplexer:
// channel count, state encoding and the rotating-priority pick function.
package stream_mux4to1_rr_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping. Scanning from the far end
  // down lets the closest hit to ptr be the last write and therefore win.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input logic [SEL_W-1:0]  ptr);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = ptr + SEL_W'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/stream_mux4to1_rr_arbiter4.sv
// Combinational round-robin picker: the first requesting channel starting
// at ptr, wrapping modulo 4.
module rr_arbiter4
  import stream_mux4to1_rr_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              gnt_valid
);

  pick_t pick;

  assign pick      = rr_pick(req, ptr);
  assign grant     = pick.idx;
  assign gnt_valid = pick.found;

endmodule

// File: rtl/stream_mux4to1_rr.sv
// Four valid/ready packet sources merged onto one registered output,
// round-robin arbitrated at packet granularity and tagged with out_sel.
module stream_mux4to1_rr
  import stream_mux4to1_rr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  state_e           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0] lock_ch, lock_ch_nxt;
  logic [SEL_W-1:0] grant, src;
  logic             gnt_valid;
  logic             load_en;
  logic             accept;

  // The single output entry can take a new beat whenever it is empty or
  // being drained this cycle, giving one beat per cycle.
  assign load_en = !out_valid || out_ready;

  rr_arbiter4 u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .gnt_valid(gnt_valid)
  );

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    in_ready    = '0;
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_ch_nxt = lock_ch;
    src         = lock_ch;
    case (state)
      IDLE: begin
        src = grant;
        if (load_en && gnt_valid) in_ready[grant] = 1'b1;
      end
      LOCKED: in_ready[lock_ch] = load_en;
      default: ;
    endcase
    if (!rst_n) in_ready = '0;
    accept = in_ready[src] && in_valid[src];
    if (accept && in_last[src]) begin
      state_nxt  = IDLE;
      rr_ptr_nxt = src + SEL_W'(1);
    end else if (accept) begin
      state_nxt   = LOCKED;
      lock_ch_nxt = src;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // Payload is held after a drain with no reload, so only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(src)*DATA_W +: DATA_W];
      out_last  <= in_last[src];
      out_sel   <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux4to1_rr.sv
// Self-checking bench for stream_mux4to1_rr: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_stream_mux4to1_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the merged output stream.
  bit         m_locked;
  int         m_owner;
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_last;
  int         m_sel;

  logic [3:0] exp_rdy;
  bit         m_load_ok;
  int         acc_ch;

  stream_mux4to1_rr #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_valid = 0; m_data = '0; m_last = 0; m_sel = 0;
  endtask

  always @(negedge rst_n) model_reset();

  // Compare process: inputs are stable from posedge+1 until the next
  // posedge, so at negedge check the DUT, then advance the model by one edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
    end else begin
      m_load_ok = !m_valid || out_ready;
      exp_rdy = '0;
      if (m_locked) begin
        if (m_load_ok) exp_rdy[m_owner] = 1'b1;
      end else if (m_load_ok) begin
        for (int k = 0; k < 4; k++) begin
          if (in_valid[(m_ptr + k) % 4]) begin
            exp_rdy[(m_ptr + k) % 4] = 1'b1;
            break;
          end
        end
      end
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_last", 32'(out_last), 32'(m_last));
      check("out_sel", 32'(out_sel), 32'(m_sel));
      acc_ch = -1;
      for (int i = 0; i < 4; i++) if (exp_rdy[i] && in_valid[i]) acc_ch = i;
      if (acc_ch >= 0) begin
        m_valid = 1;
        m_data  = in_data[acc_ch*8 +: 8];
        m_last  = in_last[acc_ch];
        m_sel   = acc_ch;
        if (in_last[acc_ch]) begin
          m_locked = 0;
          m_ptr    = (acc_ch + 1) % 4;
        end else begin
          m_locked = 1;
          m_owner  = acc_ch;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int  cnt[4];
  int  beats_before;
  bit  seen0;

  initial begin
    // Reset: sources already valid, nothing may be accepted.
    in_valid = 4'hF; in_last = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    #3;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-beat round robin with no bubbles.
    for (int n = 0; n < 5; n++) begin
      step();
      check("rr_sel", 32'(out_sel), 32'(n % 4));
      check("rr_data", 32'(out_data), 32'(8'hA0 + 8'(n % 4)));
      check("rr_valid", 32'(out_valid), 32'h1);
    end

    // Packet lock on ch2 while ch0/ch1 request; then ch0 since ch3 is idle.
    in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h00210000;
    step();
    check("lock_b0_sel", 32'(out_sel), 32'h2);
    check("lock_b0_data", 32'(out_data), 32'h21);
    in_valid = 4'b0111; in_last = 4'b0011; in_data = 32'h00221030;
    step();
    check("lock_b1_sel", 32'(out_sel), 32'h2);
    check("lock_b1_data", 32'(out_data), 32'h22);
    in_last = 4'b0111; in_data = 32'h00231030;
    step();
    check("lock_b2_sel", 32'(out_sel), 32'h2);
    check("lock_b2_data", 32'(out_data), 32'h23);
    check("lock_b2_last", 32'(out_last), 32'h1);
    in_valid = 4'b0011;
    step();
    check("after_lock_sel", 32'(out_sel), 32'h0);

    // Backpressure: hold 0x55 from ch1 for 5 cycles, then drain and load.
    in_valid = 4'b0010; in_last = 4'hF; in_data = 32'h00005500;
    step();
    check("bp_load_sel", 32'(out_sel), 32'h1);
    out_ready = 1'b0; in_valid = 4'hF; in_data = 32'h66776688;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    for (int n = 0; n < 5; n++) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'h55);
      check("bp_hold_sel", 32'(out_sel), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'b0100);
    step();
    check("bp_reload_data", 32'(out_data), 32'h77);
    check("bp_reload_sel", 32'(out_sel), 32'h2);

    // Locked source stall: ch1 locked, drops valid while ch3 waits.
    in_valid = 4'b0010; in_last = 4'b0000; in_data = 32'h00001100;
    step();
    check("stall_lock_sel", 32'(out_sel), 32'h1);
    in_valid = 4'b1000; in_last = 4'b1000;
    for (int n = 0; n < 2; n++) begin
      #1;
      check("stall_ch3_blocked", 32'(in_ready[3]), 32'h0);
      step();
      check("stall_bubble", 32'(out_valid), 32'h0);
    end
    in_valid = 4'b1010; in_last = 4'b1010; in_data = 32'h00001200;
    step();
    check("stall_resume_sel", 32'(out_sel), 32'h1);
    check("stall_resume_data", 32'(out_data), 32'h12);
    in_valid = 4'b1000;
    step();
    check("stall_next_sel", 32'(out_sel), 32'h3);

    // Starvation bound: park rr_ptr at 1, then ch1..ch3 send 4-beat packets.
    in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h00000009;
    step();
    check("starve_setup_sel", 32'(out_sel), 32'h0);
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    beats_before = 0; seen0 = 0;
    for (int n = 0; n < 20 && !seen0; n++) begin
      in_last[0] = 1'b1;
      for (int i = 1; i < 4; i++) in_last[i] = (cnt[i] == 3);
      in_data = $urandom;
      step();
      if (out_sel == 2'd0) seen0 = 1;
      else begin
        beats_before++;
        cnt[out_sel] = (cnt[out_sel] + 1) % 4;
      end
    end
    check("starve_ch0_granted", 32'(seen0), 32'h1);
    check("starve_beats_before", 32'(beats_before), 32'd12);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 1500; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_last   = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset mid-stream with a beat held: outputs clear without a clock edge.
    in_valid = 4'b0001; in_last = 4'b0000; in_data = 32'h000000EE; out_ready = 1'b0;
    step();
    step();
    check("midrst_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    check("midrst_last", 32'(out_last), 32'h0);
    check("midrst_sel", 32'(out_sel), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 32'hD3D2D1D0; out_ready = 1'b1;
    step();
    check("postrst_sel", 32'(out_sel), 32'h0);
    check("postrst_data", 32'(out_data), 32'hD0);
    step();
    check("postrst_next_sel", 32'(out_sel), 32'h1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
